// File: rtl/dpcm_decoder_if.sv
// Handshake and result bus between the DPCM encoder output side and the
// DPCM decoder. The master drives differences in; the slave returns the
// reconstructed samples and the saturation count.
interface dpcm_decoder_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              Valid;
    logic [DATA_W-1:0] DataIn;
    logic              Clear;
    logic              Ready;
    logic [DATA_W-1:0] DataOut;
    logic              OutValid;
    logic [CNT_W-1:0]  SatCount;

    modport master (
        output Valid, DataIn, Clear,
        input  Ready, DataOut, OutValid, SatCount
    );

    modport slave (
        input  Valid, DataIn, Clear,
        output Ready, DataOut, OutValid, SatCount
    );
endinterface

// File: rtl/dpcm_decoder.sv
// DPCM reconstruction stage: adds each signed difference to the last
// reconstructed sample, clamps the result to the unsigned sample range,
// publishes it and keeps it as the next predictor. Four-cycle iterative
// datapath (IDLE -> SUM -> CLAMP -> DONE), one sample per acceptance.
module dpcm_decoder #(
    parameter int DATA_W   = 32,
    parameter int SAMPLE_W = 8,
    parameter int CNT_W    = 16
) (
    input  logic           clk,
    input  logic           rst,
    dpcm_decoder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SUM   = 2'd1,
        CLAMP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_r;
    logic [DATA_W-1:0]      diff_r;
    logic [SAMPLE_W-1:0]    pred_r;
    logic signed [DATA_W:0] sum_r;
    logic [SAMPLE_W-1:0]    result_r;
    logic                   sat_r;
    logic                   ready_r;
    logic [DATA_W-1:0]      data_out_r;
    logic                   out_valid_r;
    logic [CNT_W-1:0]       sat_count_r;
    logic signed [DATA_W:0] sum_s;

    // Clamp a DATA_W+1 bit signed sum into 0..2^SAMPLE_W-1.
    // Returns {saturation_event, clamped_sample}.
    function automatic logic [SAMPLE_W:0] clamp_sample(input logic [DATA_W:0] sum);
        if (sum[DATA_W]) begin
            return {1'b1, {SAMPLE_W{1'b0}}};
        end else if (|sum[DATA_W-1:SAMPLE_W]) begin
            return {1'b1, {SAMPLE_W{1'b1}}};
        end else begin
            return {1'b0, sum[SAMPLE_W-1:0]};
        end
    endfunction

    // One extra bit of headroom: unsigned predictor plus any signed difference never overflows.
    always_comb begin
        sum_s = $signed({{(DATA_W+1-SAMPLE_W){1'b0}}, pred_r})
              + $signed({diff_r[DATA_W-1], diff_r});
    end

    // Control FSM and datapath registers; all outputs are registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            diff_r      <= '0;
            pred_r      <= '0;
            sum_r       <= '0;
            result_r    <= '0;
            sat_r       <= 1'b0;
            ready_r     <= 1'b1;
            data_out_r  <= '0;
            out_valid_r <= 1'b0;
            sat_count_r <= '0;
        end else begin
            out_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    ready_r <= 1'b1;
                    // Clear lands on the same edge as a possible capture, so a
                    // simultaneously accepted sample is summed against zero.
                    if (bus.Clear) begin
                        pred_r <= '0;
                    end
                    if (bus.Valid) begin
                        diff_r  <= bus.DataIn;
                        ready_r <= 1'b0;
                        state_r <= SUM;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SUM: begin
                    sum_r   <= sum_s;
                    state_r <= CLAMP;
                end
                CLAMP: begin
                    {sat_r, result_r} <= clamp_sample(sum_r);
                    state_r           <= DONE;
                end
                DONE: begin
                    pred_r      <= result_r;
                    data_out_r  <= {{(DATA_W-SAMPLE_W){1'b0}}, result_r};
                    out_valid_r <= 1'b1;
                    if (sat_r && (sat_count_r != {CNT_W{1'b1}})) begin
                        sat_count_r <= sat_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.Ready    = ready_r;
    assign bus.DataOut  = data_out_r;
    assign bus.OutValid = out_valid_r;
    assign bus.SatCount = sat_count_r;

endmodule

// File: tb/tb_dpcm_decoder.sv
// Directed testbench for dpcm_decoder with hand-computed expected values.
module tb_dpcm_decoder;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    dpcm_decoder_if #(.DATA_W(32), .CNT_W(16)) bus();

    dpcm_decoder #(.DATA_W(32), .SAMPLE_W(8), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one difference, wait for its result. lat counts falling edges after
    // Valid is dropped until OutValid is seen (-1 on timeout).
    task automatic do_xfer(input logic [31:0] diff, input logic clr, input logic clr_busy,
                           output int lat, output logic [31:0] dout, output logic ov_after);
        @(negedge clk);
        bus.Valid  = 1'b1;
        bus.DataIn = diff;
        bus.Clear  = clr;
        @(negedge clk);
        bus.Valid = 1'b0;
        bus.Clear = clr_busy;
        lat  = -1;
        dout = bus.DataOut;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            bus.Clear = 1'b0;
            if (bus.OutValid === 1'b1) begin
                lat  = i;
                dout = bus.DataOut;
                break;
            end
        end
        @(negedge clk);
        ov_after = bus.OutValid;
    endtask

    task automatic test_reset();
        int lat; logic [31:0] d; logic ova;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        do_xfer(32'd9, 1'b0, 1'b0, lat, d, ova);
        checks++;
        if (d !== 32'd9) begin errors++; $display("FAIL reset_pre_data: got %0d want 9", d); end
        do_xfer(32'd300, 1'b0, 1'b0, lat, d, ova);
        checks++;
        if (d !== 32'd255) begin errors++; $display("FAIL reset_pre_clamp: got %0d want 255", d); end
        checks++;
        if (bus.SatCount !== 16'd1) begin errors++; $display("FAIL reset_pre_sat: got %0d want 1", bus.SatCount); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.Ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.Ready); end
        checks++;
        if (bus.DataOut !== 32'd0) begin errors++; $display("FAIL reset_dataout: got %0d want 0", bus.DataOut); end
        checks++;
        if (bus.OutValid !== 1'b0) begin errors++; $display("FAIL reset_outvalid: got %b want 0", bus.OutValid); end
        checks++;
        if (bus.SatCount !== 16'd0) begin errors++; $display("FAIL reset_satcount: got %0d want 0", bus.SatCount); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_sequence();
        int lat; logic [31:0] d; logic ova;
        logic [31:0] diffs [3];
        logic [31:0] exps  [3];
        diffs = '{32'd10, 32'd5, 32'hFFFF_FFFD};
        exps  = '{32'd10, 32'd15, 32'd12};
        for (int k = 0; k < 3; k++) begin
            do_xfer(diffs[k], 1'b0, 1'b0, lat, d, ova);
            checks++;
            if (d !== exps[k]) begin errors++; $display("FAIL seq_data[%0d]: got %0d want %0d", k, d, exps[k]); end
            checks++;
            if (lat !== 3) begin errors++; $display("FAIL seq_latency[%0d]: got %0d want 3", k, lat); end
            checks++;
            if (ova !== 1'b0) begin errors++; $display("FAIL seq_pulse[%0d]: OutValid still %b want 0", k, ova); end
        end
        checks++;
        if (bus.SatCount !== 16'd0) begin errors++; $display("FAIL seq_satcount: got %0d want 0", bus.SatCount); end
    endtask

    task automatic test_clamp();
        int lat; logic [31:0] d; logic ova;
        do_xfer(32'd238, 1'b0, 1'b0, lat, d, ova);
        checks++;
        if (d !== 32'd250) begin errors++; $display("FAIL clamp_setup: got %0d want 250", d); end
        do_xfer(32'd20, 1'b0, 1'b0, lat, d, ova);
        checks++;
        if (d !== 32'd255) begin errors++; $display("FAIL clamp_high: got %0d want 255", d); end
        checks++;
        if (bus.SatCount !== 16'd1) begin errors++; $display("FAIL clamp_high_sat: got %0d want 1", bus.SatCount); end
        do_xfer(32'hFFFF_FED4, 1'b0, 1'b0, lat, d, ova);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL clamp_low: got %0d want 0", d); end
        checks++;
        if (bus.SatCount !== 16'd2) begin errors++; $display("FAIL clamp_low_sat: got %0d want 2", bus.SatCount); end
    endtask

    task automatic test_extremes();
        int lat; logic [31:0] d; logic ova;
        do_xfer(32'h8000_0000, 1'b0, 1'b0, lat, d, ova);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL ext_min: got %0d want 0", d); end
        checks++;
        if (bus.SatCount !== 16'd3) begin errors++; $display("FAIL ext_min_sat: got %0d want 3", bus.SatCount); end
        do_xfer(32'h7FFF_FFFF, 1'b0, 1'b0, lat, d, ova);
        checks++;
        if (d !== 32'd255) begin errors++; $display("FAIL ext_max: got %0d want 255", d); end
        checks++;
        if (bus.SatCount !== 16'd4) begin errors++; $display("FAIL ext_max_sat: got %0d want 4", bus.SatCount); end
    endtask

    task automatic test_clear_valid();
        int lat; logic [31:0] d; logic ova;
        int acc_cnt; int ov_cnt;
        int acc_idx [3];
        do_xfer(32'hFFFF_FF65, 1'b0, 1'b0, lat, d, ova);   // 255 - 155
        checks++;
        if (d !== 32'd100) begin errors++; $display("FAIL clr_setup: got %0d want 100", d); end
        do_xfer(32'd7, 1'b1, 1'b0, lat, d, ova);
        checks++;
        if (d !== 32'd7) begin errors++; $display("FAIL clr_with_valid: got %0d want 7", d); end
        // Valid held high for 10 cycles with difference +1
        acc_cnt = 0;
        ov_cnt  = 0;
        @(negedge clk);
        bus.Valid  = 1'b1;
        bus.DataIn = 32'd1;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) bus.Valid = 1'b0;
            if (bus.OutValid === 1'b1) ov_cnt++;
            if (bus.Valid === 1'b1 && bus.Ready === 1'b1) begin
                if (acc_cnt < 3) acc_idx[acc_cnt] = i;
                acc_cnt++;
            end
            @(negedge clk);
        end
        bus.Valid = 1'b0;
        checks++;
        if (acc_cnt !== 3) begin errors++; $display("FAIL hold_accepts: got %0d want 3", acc_cnt); end
        checks++;
        if (ov_cnt !== 3) begin errors++; $display("FAIL hold_outvalids: got %0d want 3", ov_cnt); end
        if (acc_cnt >= 3) begin
            checks++;
            if ((acc_idx[1] - acc_idx[0]) !== 4 || (acc_idx[2] - acc_idx[1]) !== 4) begin
                errors++;
                $display("FAIL hold_spacing: got %0d,%0d,%0d want 0,4,8", acc_idx[0], acc_idx[1], acc_idx[2]);
            end
        end
        checks++;
        if (bus.DataOut !== 32'd10) begin errors++; $display("FAIL hold_data: got %0d want 10", bus.DataOut); end
        // Clear while busy must be ignored
        do_xfer(32'd5, 1'b0, 1'b1, lat, d, ova);
        checks++;
        if (d !== 32'd15) begin errors++; $display("FAIL clr_busy: got %0d want 15", d); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] d; logic ova;
        int ov_seen;
        @(negedge clk);
        bus.Valid  = 1'b1;
        bus.DataIn = 32'd1;
        @(negedge clk);                 // SUM
        bus.Valid = 1'b0;
        @(negedge clk);                 // CLAMP
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.DataOut !== 32'd0) begin errors++; $display("FAIL mid_reset_data: got %0d want 0", bus.DataOut); end
        ov_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) rst = 1'b1;
            if (bus.OutValid === 1'b1) ov_seen++;
        end
        checks++;
        if (ov_seen !== 0) begin errors++; $display("FAIL mid_reset_outvalid: got %0d pulses want 0", ov_seen); end
        do_xfer(32'd4, 1'b0, 1'b0, lat, d, ova);
        checks++;
        if (d !== 32'd4) begin errors++; $display("FAIL mid_reset_after: got %0d want 4", d); end
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL mid_reset_latency: got %0d want 3", lat); end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b0;
        bus.Valid  = 1'b0;
        bus.DataIn = 32'd0;
        bus.Clear  = 1'b0;
        test_reset();
        test_sequence();
        test_clamp();
        test_extremes();
        test_clear_valid();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpcm_decoder.md
# dpcm_decoder

Reconstruction stage directly downstream of the DPCM encoder: accepts one saturated signed difference per handshake and adds it to an internal predictor (the last reconstructed sample). Each result is clamped to the unsigned sample range, presented on DataOut, and becomes the next predictor. Data ports use the same Valid/Ready/DataIn/DataOut naming and widths as the encoder's output side, so the two stages connect point-to-point in the codec loopback path.

## Interface
- DATA_W, 32: width of DataIn/DataOut; DataIn is two's-complement.
- SAMPLE_W, 8: reconstructed sample width; range 0 .. 2^SAMPLE_W-1.
- CNT_W, 16: width of the saturation event counter.
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset (asserts immediately, releases synchronously to clk).
- Valid  in  1  DataIn holds a difference; sampled only while Ready=1.
- DataIn  in  DATA_W  signed difference.
- Clear  in  1  zero the predictor; honoured only in IDLE.
- Ready  out  1  1 = idle, can accept; 0 = busy.
- DataOut  out  DATA_W  last reconstructed sample, zero-extended; held until next result.
- OutValid  out  1  one-cycle strobe when DataOut updates.
- SatCount  out  CNT_W  count of clamped results; saturates at all-ones.

## Operation
- States: IDLE, SUM, CLAMP, DONE. Reset state IDLE.
- Reset values: Ready=1, DataOut=0, OutValid=0, SatCount=0, predictor=0, internal sum=0.
- IDLE: Ready=1. On an edge with Valid=1, capture DataIn into a difference register and go to SUM; Ready=0 from that edge. Otherwise stay in IDLE.
- Clear=1 in IDLE zeroes the predictor on that edge. If Valid=1 on the same edge, the sample is accepted and computed against predictor 0: Clear takes effect first.
- Clear in SUM, CLAMP or DONE is ignored; it is not queued.
- Valid in SUM, CLAMP or DONE is ignored: no capture and no queueing. Exactly one sample is accepted per Ready=1 acceptance edge.
- SUM: sum = zero-extend(predictor) + sign-extend(diff), computed at DATA_W+1 bits so no intermediate overflow is possible. Go to CLAMP.
- CLAMP:
  - sum < 0 gives result 0, a saturation event.
  - sum > 2^SAMPLE_W-1 gives result 2^SAMPLE_W-1, a saturation event.
  - Otherwise result = sum[SAMPLE_W-1:0].
  - Go to DONE.
- DONE:
  - predictor <= result.
  - DataOut <= zero-extended result.
  - OutValid=1 for this one cycle only.
  - SatCount increments on a saturation event, unless already all-ones.
  - Ready=1 again. Next state IDLE.
- Reset asserted in any state: immediate return to reset values. No OutValid is produced for the in-flight sample and the predictor is lost.

## Timing
- Accept edge N (Valid=1 and Ready=1).
- SUM occupies the cycle after N, CLAMP the next; registered DataOut, OutValid=1 and Ready=1 take effect on edge N+3.
- Earliest next accept is edge N+4, so sustained throughput is 1 sample per 4 cycles.
- OutValid is high for exactly one cycle per accepted sample.
- DataOut and SatCount change only on a DONE edge or on reset.
- Ready never goes high mid-operation; the upstream stage may hold Valid continuously.

## Test plan
- Reset: rst=0 mid-cycle -> Ready=1, DataOut=0, OutValid=0, SatCount=0 before the next clk edge.
- Sequence: diffs +10, +5, -3 (0xFFFFFFFD) -> DataOut 10, 15, 12. Each appears 3 edges after its accept with a single OutValid pulse, and SatCount stays 0.
- Clamping: predictor 250, diff +20 -> 255, SatCount=1. Then diff -300 (0xFFFFFED4) -> 0, SatCount=2.
- Width extremes: from 0, diff 0x80000000 -> 0, SatCount+1. Then diff 0x7FFFFFFF -> 255, SatCount+1, with no wrap to small values.
- Clear/Valid interaction: predictor 100.
  - Clear=1 and Valid=1 with diff 7 in IDLE -> 7.
  - Valid held high for 10 cycles -> exactly 3 accepts, spaced 4 cycles apart.
  - Clear pulsed while busy -> no effect.
- Reset mid-operation: assert rst during CLAMP -> no OutValid, DataOut=0. After release, diff 4 -> DataOut 4.
